// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - request/response and APB bus bundle for apb_master
//
// Purpose: groups the requester-side valid/ready channels and the APB
// initiator signals into one interface.
// Modports:
//   master - view of apb_master: consumes requests, produces responses,
//            drives psel/penable/paddr/pwrite/pwdata/pwstrb, samples
//            pready/prdata/pslverr.
//   slave  - mirror view for whatever sits around the bridge (requester
//            plus APB slave), e.g. a testbench.
interface apb_master_if #(
  parameter int ADDR_W = 32
) ();
  // request channel
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  // response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  // APB
  logic              psel;
  logic              penable;
  logic              pready;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pwstrb;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output psel, penable, paddr, pwrite, pwdata, pwstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  psel, penable, paddr, pwrite, pwdata, pwstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready request/response to APB initiator bridge
//
// Purpose: issues one APB transfer (SETUP then ACCESS) per accepted request
// and returns read data / error status on the response channel. Only one
// transfer is in flight at a time.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - apb_master_if.master: req_*, resp_* and APB signals
// Parameters:
//   ADDR_W         - address width (req_addr, paddr)
//   TIMEOUT_CYCLES - ACCESS wait limit, only used with APB_TIMEOUT_EN
// Optional feature macro: APB_TIMEOUT_EN
//   defined   - ACCESS is abandoned with resp_err = 1 after TIMEOUT_CYCLES
//               wait cycles (pready = 1 on the final cycle still wins)
//   undefined - ACCESS waits for pready indefinitely
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  apb_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pwstrb_q, pwstrb_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  // A zero limit would abandon every transfer before the slave can answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout;

  assign timeout = (wait_cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pwstrb_d     = pwstrb_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          pwdata_d = bus.req_wdata;
          // reads never carry strobes on the bus
          pwstrb_d = bus.req_write ? bus.req_wstrb : 4'b0000;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      S_ACCESS: begin
        if (bus.pready) begin
          resp_rdata_d = pwrite_q ? 32'h0 : bus.prdata;
          resp_err_d   = bus.pslverr;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (timeout) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= 32'h0;
      pwstrb_q     <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pwstrb_q     <= pwstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pwstrb     = pwstrb_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

  localparam int TO    = 4;
  localparam int NEVER = 1000000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  apb_master_if #(.ADDR_W(32)) bus ();

  apb_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of one transfer from the protocol rules: how many ACCESS
  // cycles it takes, and what the response carries.
  function automatic void model(input logic w, input int waits, input logic [31:0] rd,
                                input logic se, output int acc, output logic [31:0] rdata,
                                output logic err);
    logic to_en;
`ifdef APB_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    if (to_en && waits > TO) begin
      acc = TO + 1; rdata = 32'h0; err = 1'b1;
    end else begin
      acc = waits + 1; rdata = w ? 32'h0 : rd; err = se;
    end
  endfunction

  // Runs one request through the bridge while acting as the APB slave and the
  // response consumer; reports what was observed.
  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] ws, input int waits, input logic [31:0] rd,
                          input logic se, input int rdly, input int max_cyc,
                          output int setup_n, output int acc_n, output int setup_at,
                          output int resp_at, output logic got, output logic [31:0] o_rdata,
                          output logic o_err, output int bus_bad, output int hold_bad,
                          output logic rr_after);
    logic [3:0] exp_strb;
    int cyc;
    exp_strb = w ? ws : 4'b0000;
    setup_n = 0; acc_n = 0; setup_at = 0; resp_at = 0; got = 1'b0;
    o_rdata = 32'h0; o_err = 1'b0; bus_bad = 0; hold_bad = 0; rr_after = 1'b0;
    @(negedge clk);
    if (!bus.req_ready) hold_bad++;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_write = w;
    bus.req_wdata = wd; bus.req_wstrb = ws; bus.resp_ready = (rdly == 0);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    bus.req_wstrb = 4'($urandom); bus.req_write = ~w;
    cyc = 1;
    while (!got && cyc <= max_cyc) begin
      if (bus.psel && (bus.paddr !== a || bus.pwrite !== w || bus.pwdata !== wd ||
                       bus.pwstrb !== exp_strb)) bus_bad++;
      if (bus.psel && !bus.penable) begin
        setup_n++;
        if (setup_at == 0) setup_at = cyc;
      end
      if (bus.psel && bus.penable) begin
        acc_n++;
        if (acc_n == waits + 1) begin
          bus.pready = 1'b1; bus.prdata = rd; bus.pslverr = se;
        end else begin
          bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'($urandom);
        end
      end else begin
        bus.pready = 1'b0; bus.pslverr = 1'($urandom); bus.prdata = $urandom;
      end
      if (bus.resp_valid) begin
        got = 1'b1; resp_at = cyc; o_rdata = bus.resp_rdata; o_err = bus.resp_err;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (got) begin
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk);
        if (!bus.resp_valid || bus.resp_rdata !== o_rdata || bus.resp_err !== o_err ||
            bus.req_ready || bus.psel) hold_bad++;
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      if (bus.resp_valid || bus.psel) hold_bad++;
      rr_after = bus.req_ready;
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.psel !== 1'b0) begin n_fail++; $display("FAIL reset_psel got %b want 0", bus.psel); end
    n_checks++; if (bus.penable !== 1'b0) begin n_fail++; $display("FAIL reset_penable got %b want 0", bus.penable); end
    n_checks++; if (bus.pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_pwrite got %b want 0", bus.pwrite); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b want 0", bus.resp_err); end
    n_checks++; if (bus.paddr !== 32'h0) begin n_fail++; $display("FAIL reset_paddr got %h want 0", bus.paddr); end
    n_checks++; if (bus.pwdata !== 32'h0) begin n_fail++; $display("FAIL reset_pwdata got %h want 0", bus.pwdata); end
    n_checks++; if (bus.pwstrb !== 4'h0) begin n_fail++; $display("FAIL reset_pwstrb got %h want 0", bus.pwstrb); end
    n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    int sn, an, sa, ra, bb, hb; logic g, e, rr; logic [31:0] rd;
    run_xfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, 32'hFFFF_FFFF, 1'b0, 0, 50,
             sn, an, sa, ra, g, rd, e, bb, hb, rr);
    n_checks++; if (sa !== 1 || sn !== 1) begin n_fail++; $display("FAIL wr_setup at=%0d n=%0d want at=1 n=1", sa, sn); end
    n_checks++; if (an !== 1) begin n_fail++; $display("FAIL wr_access_cycles got %0d want 1", an); end
    n_checks++; if (!g || ra !== 3) begin n_fail++; $display("FAIL wr_resp_cycle got=%b cyc=%0d want cyc 3", g, ra); end
    n_checks++; if (rd !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL wr_resp rdata=%h err=%b want 0/0", rd, e); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL wr_bus_fields bad=%0d want 0", bb); end
    n_checks++; if (hb !== 0 || rr !== 1'b1) begin n_fail++; $display("FAIL wr_ready_cycle4 hold_bad=%0d req_ready=%b want 0/1", hb, rr); end
    n_checks++; if (bus.paddr !== 32'h10 || bus.pwstrb !== 4'b0011) begin n_fail++; $display("FAIL wr_idle_hold paddr=%h pwstrb=%b want 10/0011", bus.paddr, bus.pwstrb); end
  endtask

  task automatic test_read_waits();
    int sn, an, sa, ra, bb, hb; logic g, e, rr; logic [31:0] rd;
    run_xfer(32'h0000_0200, 1'b0, 32'h5555_AAAA, 4'b1111, 3, 32'h1234_5678, 1'b0, 0, 50,
             sn, an, sa, ra, g, rd, e, bb, hb, rr);
    n_checks++; if (an !== 4) begin n_fail++; $display("FAIL rd_access_cycles got %0d want 4", an); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL rd_bus_stable bad=%0d want 0", bb); end
    n_checks++; if (!g || rd !== 32'h1234_5678 || e !== 1'b0) begin n_fail++; $display("FAIL rd_resp rdata=%h err=%b want 12345678/0", rd, e); end
    n_checks++; if (ra !== 6) begin n_fail++; $display("FAIL rd_resp_cycle got %0d want 6", ra); end
  endtask

  task automatic test_slave_err();
    int sn, an, sa, ra, bb, hb; logic g, e, rr; logic [31:0] rd;
    run_xfer(32'h0010_0000, 1'b0, 32'h0, 4'b0000, 1, 32'hCAFE_0001, 1'b1, 0, 50,
             sn, an, sa, ra, g, rd, e, bb, hb, rr);
    n_checks++; if (!g || e !== 1'b1 || rd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL err_resp err=%b rdata=%h want 1/cafe0001", e, rd); end
    run_xfer(32'h0000_0044, 1'b1, 32'h0BAD_F00D, 4'b1000, 0, 32'h0, 1'b0, 0, 50,
             sn, an, sa, ra, g, rd, e, bb, hb, rr);
    n_checks++; if (!g || e !== 1'b0 || hb !== 0 || sa !== 1) begin n_fail++; $display("FAIL err_next_req err=%b hold_bad=%0d setup_at=%0d want 0/0/1", e, hb, sa); end
  endtask

  task automatic test_backpressure();
    int sn, an, sa, ra, bb, hb; logic g, e, rr; logic [31:0] rd;
    run_xfer(32'h0000_0300, 1'b0, 32'h0, 4'b0000, 0, 32'h8765_4321, 1'b1, 5, 50,
             sn, an, sa, ra, g, rd, e, bb, hb, rr);
    n_checks++; if (!g || rd !== 32'h8765_4321 || e !== 1'b1) begin n_fail++; $display("FAIL bp_resp rdata=%h err=%b want 87654321/1", rd, e); end
    n_checks++; if (hb !== 0) begin n_fail++; $display("FAIL bp_hold bad=%0d want 0", hb); end
    n_checks++; if (rr !== 1'b1) begin n_fail++; $display("FAIL bp_req_ready_after got %b want 1", rr); end
  endtask

  task automatic test_reset_mid();
    int sn, an, sa, ra, bb, hb, acc; logic g, e, rr; logic [31:0] rd;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0400; bus.req_write = 1'b0;
    bus.pready = 1'b0; bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.psel && bus.penable) acc++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL rst_mid_in_access cycles=%0d want 4", acc); end
    n_checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop psel=%b penable=%b resp_valid=%b want 000", bus.psel, bus.penable, bus.resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req_ready got %b want 1", bus.req_ready); end
    run_xfer(32'h0000_0500, 1'b1, 32'h1357_9BDF, 4'b0101, 1, 32'h0, 1'b0, 0, 50,
             sn, an, sa, ra, g, rd, e, bb, hb, rr);
    n_checks++; if (!g || e !== 1'b0 || an !== 2 || sn !== 1 || bb !== 0 || rr !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after got=%b err=%b acc=%0d setup=%0d bus_bad=%0d rr=%b", g, e, an, sn, bb, rr); end
  endtask

  task automatic test_timeout();
    int sn, an, sa, ra, bb, hb; logic g, e, rr; logic [31:0] rd;
    run_xfer(32'h0000_0600, 1'b0, 32'h0, 4'b0000, NEVER, 32'hAAAA_5555, 1'b0, 0, 150,
             sn, an, sa, ra, g, rd, e, bb, hb, rr);
`ifdef APB_TIMEOUT_EN
    n_checks++; if (!g || an !== TO + 1) begin n_fail++; $display("FAIL to_access_cycles got=%b cycles=%0d want %0d", g, an, TO + 1); end
    n_checks++; if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL to_resp err=%b rdata=%h want 1/0", e, rd); end
`else
    n_checks++; if (g || an < 100) begin n_fail++; $display("FAIL to_wait_forever got_resp=%b cycles=%0d want none/>=100", g, an); end
    n_checks++; if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin n_fail++; $display("FAIL to_still_access psel=%b penable=%b want 11", bus.psel, bus.penable); end
    pulse_reset();
`endif
  endtask

  task automatic test_random();
    int sn, an, sa, ra, bb, hb, waits, rdly, exp_acc; logic g, e, rr, w, se, exp_err;
    logic [31:0] rd, a, wd, prd, exp_rd; logic [3:0] ws;
    for (int t = 0; t < 24; t++) begin
      a = $urandom; w = 1'($urandom); wd = $urandom; ws = 4'($urandom);
      prd = $urandom; se = 1'($urandom); waits = $urandom_range(0, 6); rdly = $urandom_range(0, 3);
      model(w, waits, prd, se, exp_acc, exp_rd, exp_err);
      run_xfer(a, w, wd, ws, waits, prd, se, rdly, 60, sn, an, sa, ra, g, rd, e, bb, hb, rr);
      n_checks++;
      if (!g || an !== exp_acc || ra !== exp_acc + 2 || sa !== 1 || sn !== 1 || rd !== exp_rd ||
          e !== exp_err || bb !== 0 || hb !== 0 || rr !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_%0d got=%b acc=%0d/%0d resp_at=%0d/%0d rdata=%h/%h err=%b/%b bus_bad=%0d hold_bad=%0d rr=%b",
                 t, g, an, exp_acc, ra, exp_acc + 2, rd, exp_rd, e, exp_err, bb, hb, rr);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
    bus.req_wstrb = '0; bus.resp_ready = 1'b0; bus.pready = 1'b0; bus.prdata = '0;
    bus.pslverr = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_err();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Bridge from a simple valid/ready request/response port to an APB initiator.
- Lets a core-side or DMA-side requester drive APB slaves such as the system RAM and peripherals.
- Issues one APB transfer per request: SETUP, then ACCESS. Returns read data and error status on a separate response channel.
- One transfer outstanding at a time.

Parameters:
- ADDR_W, 32, width of req_addr and paddr.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit. Used only when APB_TIMEOUT_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_addr  input  ADDR_W  byte address
- req_write  input  1  1 = write, 0 = read
- req_wdata  input  32  write data
- req_wstrb  input  4  byte-lane write strobes
- resp_valid  output  1  response present
- resp_ready  input  1  response consumed when resp_valid & resp_ready
- resp_rdata  output  32  read data; 0 for writes
- resp_err  output  1  pslverr captured at completion, or timeout
- psel  output  1  APB select
- penable  output  1  APB enable
- pready  input  1  APB ready
- paddr  output  ADDR_W  APB address
- pwrite  output  1  APB direction
- pwdata  output  32  APB write data
- pwstrb  output  4  APB strobes
- prdata  input  32  APB read data
- pslverr  input  1  APB slave error

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. psel, penable, pwrite, resp_valid and resp_err = 0. paddr, pwdata, pwstrb and resp_rdata = 0.
- Reset mid-transfer aborts immediately: psel/penable drop with no response. Deassertion is sampled synchronously.
- All APB outputs are registered. req_ready = (state == IDLE), combinational from state only.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid, register paddr = req_addr, pwrite = req_write, pwdata = req_wdata.
  - Register pwstrb = req_write ? req_wstrb : 4'b0; read strobes are forced to zero.
  - Next state SETUP.
- SETUP: psel = 1, penable = 0. Next state is always ACCESS.
- ACCESS: psel = 1, penable = 1.
  - pready = 0: stay in ACCESS; paddr, pwrite, pwdata and pwstrb stay stable.
  - pready = 1: capture resp_rdata = pwrite ? 0 : prdata and resp_err = pslverr. Drop psel/penable. Next state RESP.
- RESP: resp_valid = 1, and resp_rdata/resp_err stay stable until resp_ready.
  - On resp_ready: resp_valid drops and next state is IDLE.
  - resp_ready may be high on the first RESP cycle, which completes that same cycle.
- Latency with zero-wait slave and resp_ready tied high:
  - Request accepted at edge 0.
  - SETUP during cycle 1, ACCESS during cycle 2.
  - resp_valid high during cycle 3.
  - req_ready high again in cycle 4.
  - Peak throughput is one transfer per 4 cycles.
- psel never stays high between transfers; every transfer has its own SETUP.
- paddr, pwdata and pwstrb hold their last values while idle.
- resp_rdata/resp_err keep their last values after RESP; they are valid only while resp_valid is high.
- pslverr and prdata are sampled only when psel & penable & pready are all high.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP and increments on each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT_CYCLES and pready is still 0, the transfer is abandoned: psel/penable drop, resp_rdata = 0, resp_err = 1, next state RESP.
  - pready = 1 in that same cycle wins, giving normal completion.
- Not defined: no counter. ACCESS waits indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- Write with zero-wait slave: req addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 4'b0011 → psel high cycles 1–2, penable cycle 2 only, pwstrb = 0011, resp_valid in cycle 3 with resp_err = 0 and resp_rdata = 0.
- Read with 3 wait states: prdata = 0x1234_5678 when pready rises → ACCESS lasts 4 cycles with paddr stable throughout, pwstrb = 0, resp_rdata = 0x1234_5678.
- Slave error: read of 0x0010_0000 with pslverr = 1 at completion → resp_err = 1, next request accepted normally afterwards.
- Response backpressure: resp_ready low for 5 cycles → resp_valid and data held, req_ready stays 0, and no psel asserts until the response is consumed.
- Reset during ACCESS: rst_n low while pready = 0 → psel, penable and resp_valid go 0 immediately; after release, req_ready = 1 and a new transfer runs cleanly.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES = 4): pready held 0 → exactly 5 ACCESS cycles, then resp_err = 1 and resp_rdata = 0. Without the macro, ACCESS persists for 100+ cycles.
